// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, request class, R-type funct values and
// the sequencer state encoding.
package alu_pkg;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b011;
  localparam logic [2:0] ALU_ADD  = 3'b100;
  localparam logic [2:0] ALU_ADDU = 3'b101;
  localparam logic [2:0] ALU_SUB  = 3'b110;

  typedef enum logic [1:0] {
    CLASS_ADD   = 2'b00,
    CLASS_SUB   = 2'b01,
    CLASS_RTYPE = 2'b10,
    CLASS_OR    = 2'b11
  } alu_class_e;

  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_ADDU = 6'b100001;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } seq_state_e;

endpackage

// File: rtl/alu_decode.sv
// Combinational translation of main-control class and R-type funct into the
// 3-bit ALU control code, flagging undecodable funct values.
module alu_decode
  import alu_pkg::*;
(
  input  logic [1:0] op_class,
  input  logic [5:0] funct,
  output logic [2:0] code,
  output logic       illegal
);

  always_comb begin
    code    = ALU_ADD;
    illegal = 1'b0;
    case (alu_class_e'(op_class))
      CLASS_ADD: code = ALU_ADD;
      CLASS_SUB: code = ALU_SUB;
      CLASS_OR:  code = ALU_OR;
      CLASS_RTYPE: begin
        case (funct)
          FUNCT_ADD:  code = ALU_ADD;
          FUNCT_ADDU: code = ALU_ADDU;
          FUNCT_SUB:  code = ALU_SUB;
          FUNCT_AND:  code = ALU_AND;
          FUNCT_OR:   code = ALU_OR;
          FUNCT_SLT:  code = ALU_SLT;
          // Keep a harmless code on the bus; the request never reaches EXEC.
          default:    illegal = 1'b1;
        endcase
      end
      default: code = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue/capture front end for the combinational ALU: decode at accept, one EXEC
// cycle, then a held result. Optional overflow capture under ALU_OVF_TRAP_EN.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_class,
  input  logic [5:0]       in_funct,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_illegal,
  output logic             out_ovf
);

  seq_state_e       state_reg, state_next;
  logic [2:0]       dec_code;
  logic             dec_illegal;
  logic             accept;
  logic [WIDTH-1:0] alu_a_reg, alu_b_reg, result_reg;
  logic [2:0]       alu_ctrl_reg;
  logic             zero_reg, illegal_reg;

  alu_decode u_decode (
    .op_class (in_class),
    .funct    (in_funct),
    .code     (dec_code),
    .illegal  (dec_illegal)
  );

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = dec_illegal ? ST_DONE : ST_EXEC;
      end
      ST_EXEC: state_next = ST_DONE;
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Illegal requests leave the ALU drive untouched so it never sees a bad code.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a_reg    <= '0;
      alu_b_reg    <= '0;
      alu_ctrl_reg <= ALU_ADD;
      result_reg   <= '0;
      zero_reg     <= 1'b0;
      illegal_reg  <= 1'b0;
    end else if (state_reg == ST_IDLE && accept) begin
      illegal_reg <= dec_illegal;
      result_reg  <= '0;
      zero_reg    <= 1'b0;
      if (!dec_illegal) begin
        alu_a_reg    <= in_a;
        alu_b_reg    <= in_b;
        alu_ctrl_reg <= dec_code;
      end
    end else if (state_reg == ST_EXEC) begin
      result_reg <= alu_out;
      zero_reg   <= alu_zero;
    end
  end

`ifdef ALU_OVF_TRAP_EN
  logic ovf_reg, ovf_next;
  logic sign_a, sign_b, sign_r;

  assign sign_a = alu_a_reg[WIDTH-1];
  assign sign_b = alu_b_reg[WIDTH-1];
  assign sign_r = alu_out[WIDTH-1];

  always_comb begin
    ovf_next = 1'b0;
    if (alu_ctrl_reg == ALU_ADD)      ovf_next = (sign_a == sign_b) && (sign_r != sign_a);
    else if (alu_ctrl_reg == ALU_SUB) ovf_next = (sign_a != sign_b) && (sign_r != sign_a);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                ovf_reg <= 1'b0;
    else if (state_reg == ST_IDLE && accept) ovf_reg <= 1'b0;
    else if (state_reg == ST_EXEC)          ovf_reg <= ovf_next;
  end

  assign out_ovf = ovf_reg;
`else
  assign out_ovf = 1'b0;
`endif

  assign alu_a       = alu_a_reg;
  assign alu_b       = alu_b_reg;
  assign alu_ctrl    = alu_ctrl_reg;
  assign out_result  = result_reg;
  assign out_zero    = zero_reg;
  assign out_illegal = illegal_reg;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU attached;
// expectations follow ALU_OVF_TRAP_EN when it is defined.
module tb_alu_op_sequencer;

  localparam int W = 32;
`ifdef ALU_OVF_TRAP_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0, in_ready;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic [1:0]   in_class = 2'b00;
  logic [5:0]   in_funct = 6'd0;
  logic [W-1:0] alu_a, alu_b, alu_out, out_result;
  logic [2:0]   alu_ctrl;
  logic         alu_zero, out_valid, out_ready = 1'b0;
  logic         out_zero, out_illegal, out_ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_class(in_class), .in_funct(in_funct),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero),
    .out_illegal(out_illegal), .out_ovf(out_ovf)
  );

  // Behavioural ALU; SLT is an unsigned compare.
  always_comb begin
    case (alu_ctrl)
      3'b000:         alu_out = alu_a & alu_b;
      3'b001:         alu_out = alu_a | alu_b;
      3'b011:         alu_out = {{(W-1){1'b0}}, alu_a < alu_b};
      3'b100, 3'b101: alu_out = alu_a + alu_b;
      3'b110:         alu_out = alu_a - alu_b;
      default:        alu_out = '0;
    endcase
    alu_zero = (alu_out == '0);
  end

  typedef struct {
    logic [1:0]   cls;
    logic [5:0]   funct;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   exp_ctrl;
    logic [W-1:0] exp_result;
    logic         exp_zero;
    logic         exp_illegal;
    logic         exp_ovf;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (alu_ctrl == 3'b010 || alu_ctrl == 3'b111)) begin
      errors++;
      $display("FAIL alu_ctrl_undefined: got %b expected a defined code", alu_ctrl);
    end
  end

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    @(negedge clk);
    in_valid = 1'b1; in_class = v.cls; in_funct = v.funct; in_a = v.a; in_b = v.b;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    lat = 1;
    if (!v.exp_illegal) begin
      chk("exec_ctrl", {29'd0, alu_ctrl}, {29'd0, v.exp_ctrl});
      chk("exec_a", alu_a, v.a);
      chk("exec_b", alu_b, v.b);
      chk("exec_in_ready", {31'd0, in_ready}, 32'd0);
    end
    while (!out_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, v.exp_illegal ? 32'd1 : 32'd2);
    chk("result", out_result, v.exp_result);
    chk("zero", {31'd0, out_zero}, {31'd0, v.exp_zero});
    chk("illegal", {31'd0, out_illegal}, {31'd0, v.exp_illegal});
    chk("ovf", {31'd0, out_ovf}, {31'd0, v.exp_ovf});
    $display("txn %0d class=%b funct=%b a=0x%0h b=0x%0h -> result=0x%0h zero=%b ill=%b ovf=%b lat=%0d",
             idx, v.cls, v.funct, v.a, v.b, out_result, out_zero, out_illegal, out_ovf, lat);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("handoff_valid", {31'd0, out_valid}, 32'd0);
    chk("handoff_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    vecs[0]  = '{2'b10, 6'b100010, 32'd5,        32'd5,  3'b110, 32'd0,        1'b1, 1'b0, 1'b0};
    vecs[1]  = '{2'b00, 6'b000000, 32'h7FFFFFFF, 32'd1,  3'b100, 32'h80000000, 1'b0, 1'b0, OVF_ON};
    vecs[2]  = '{2'b10, 6'b000000, 32'd9,        32'd4,  3'b100, 32'd0,        1'b0, 1'b1, 1'b0};
    vecs[3]  = '{2'b11, 6'b101010, 32'hF0,       32'h0F, 3'b001, 32'hFF,       1'b0, 1'b0, 1'b0};
    vecs[4]  = '{2'b10, 6'b101010, 32'd3,        32'd7,  3'b011, 32'd1,        1'b0, 1'b0, 1'b0};
    vecs[5]  = '{2'b01, 6'b000000, 32'd10,       32'd3,  3'b110, 32'd7,        1'b0, 1'b0, 1'b0};
    vecs[6]  = '{2'b10, 6'b100100, 32'hFF00,     32'h0F0F, 3'b000, 32'h0F00,   1'b0, 1'b0, 1'b0};
    vecs[7]  = '{2'b10, 6'b100101, 32'hF000,     32'h000F, 3'b001, 32'hF00F,   1'b0, 1'b0, 1'b0};
    vecs[8]  = '{2'b10, 6'b100001, 32'hFFFFFFFF, 32'd1,  3'b101, 32'd0,        1'b1, 1'b0, 1'b0};
    vecs[9]  = '{2'b01, 6'b000000, 32'h80000000, 32'd1,  3'b110, 32'h7FFFFFFF, 1'b0, 1'b0, OVF_ON};
    vecs[10] = '{2'b10, 6'b100000, 32'd0,        32'd0,  3'b100, 32'd0,        1'b1, 1'b0, 1'b0};
    vecs[11] = '{2'b10, 6'b111111, 32'd1,        32'd2,  3'b100, 32'd0,        1'b0, 1'b1, 1'b0};
    vecs[12] = '{2'b10, 6'b101010, 32'hFFFFFFFF, 32'd1,  3'b011, 32'd0,        1'b1, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", out_result, 32'd0);
    chk("rst_alu_ctrl", {29'd0, alu_ctrl}, 32'd4);
    chk("rst_alu_a", alu_a, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

    // Backpressure: result must hold while in_valid is presented and ignored.
    @(negedge clk);
    in_valid = 1'b1; in_class = 2'b11; in_a = 32'hA0; in_b = 32'h05;
    @(posedge clk);
    #1 in_valid = 1'b1; in_class = 2'b00; in_a = 32'd1; in_b = 32'd1;
    for (int i = 0; i < 3 && !out_valid; i++) @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_result", out_result, 32'hA5);
    end
    $display("txn bp class=11 a=0xa0 b=0x5 -> result=0x%0h held 5 cycles", out_result);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    run_vec(vecs[5], 100);

    // Reset during EXEC aborts the operation.
    @(negedge clk);
    in_valid = 1'b1; in_class = 2'b00; in_a = 32'h1234; in_b = 32'h55;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_alu_a", alu_a, 32'd0);
    chk("mid_rst_alu_b", alu_b, 32'd0);
    chk("mid_rst_alu_ctrl", {29'd0, alu_ctrl}, 32'd4);
    chk("mid_rst_result", out_result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("post_rst_result", out_result, 32'd0);
    $display("txn rst_mid_exec -> in_ready=%b out_valid=%b", in_ready, out_valid);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
